// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: packed payload + control under valid/ready, with flush and optional skid entry.
// Latency 1 cycle; SKID=1 registers in_ready (2 entries), SKID=0 passes out_ready through to in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 24,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Only skid_valid (a flop) gates acceptance, so out_ready never reaches in_ready.
            assign in_ready = ~rst & ~skid_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                    skid_valid <= 1'b0;
                    skid_data  <= '0;
                    skid_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (out_xfer) begin
                    if (skid_valid) begin
                        main_data  <= skid_data;
                        main_ctrl  <= skid_ctrl;
                        skid_valid <= 1'b0;
                    end else if (in_xfer) begin
                        main_data  <= in_data;
                        main_ctrl  <= in_ctrl;
                    end else begin
                        main_valid <= 1'b0;
                    end
                end else if (in_xfer) begin
                    if (main_valid) begin
                        skid_data  <= in_data;
                        skid_ctrl  <= in_ctrl;
                        skid_valid <= 1'b1;
                    end else begin
                        main_data  <= in_data;
                        main_ctrl  <= in_ctrl;
                        main_valid <= 1'b1;
                    end
                end
            end
        end else begin : g_single
            assign in_ready = ~rst & (~main_valid | out_ready);

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (in_xfer) begin
                    main_data  <= in_data;
                    main_ctrl  <= in_ctrl;
                    main_valid <= 1'b1;
                end else if (out_xfer) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 default instance and a SKID=0, CNT_W=4 instance, scoreboarded per instance.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: defaults (SKID=1, 128/24/16)
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [127:0] a_in_data, a_out_data;
    logic [23:0]  a_in_ctrl, a_out_ctrl;
    logic [15:0]  a_stall_cnt;

    // instance B: SKID=0, small widths, 4-bit counter
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [7:0]   b_in_data, b_out_data;
    logic [3:0]   b_in_ctrl, b_out_ctrl;
    logic [3:0]   b_stall_cnt;

    pipe_stage_reg dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall_cnt(b_stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboards: queue holds the beats the stage should currently be holding, oldest first
    logic [151:0] qa[$];
    logic [11:0]  qb[$];
    logic [15:0]  a_stall_exp;
    logic [3:0]   b_stall_exp;
    logic         mon_en = 1'b0;

    logic         a_rdy_m, a_vld_m, b_rdy_m, b_vld_m;
    logic [151:0] a_beat;
    logic [11:0]  b_beat;

    always @(negedge clk) begin
        if (mon_en) begin
            a_rdy_m = !rst && (qa.size() < 2);
            a_vld_m = (qa.size() != 0);
            expect_eq("a_in_ready", {159'd0, a_in_ready}, {159'd0, a_rdy_m});
            expect_eq("a_out_valid", {159'd0, a_out_valid}, {159'd0, a_vld_m});
            if (!a_vld_m) expect_eq("a_ctrl_bubble", {136'd0, a_out_ctrl}, 160'd0);
            expect_eq("a_stall_cnt", {144'd0, a_stall_cnt}, {144'd0, a_stall_exp});
            if (rst) begin
                qa.delete();
                a_stall_exp = '0;
            end else begin
                if (a_vld_m && a_out_ready) begin
                    a_beat = qa.pop_front();
                    expect_eq("a_out_beat", {8'd0, a_out_data, a_out_ctrl}, {8'd0, a_beat});
                end
                if (a_in_valid && a_rdy_m) qa.push_back({a_in_data, a_in_ctrl});
                if (a_flush) qa.delete();
                if (a_vld_m && !a_out_ready && a_stall_exp != 16'hFFFF) a_stall_exp = a_stall_exp + 16'd1;
            end

            b_vld_m = (qb.size() != 0);
            b_rdy_m = !rst && (!b_vld_m || b_out_ready);
            expect_eq("b_in_ready", {159'd0, b_in_ready}, {159'd0, b_rdy_m});
            expect_eq("b_out_valid", {159'd0, b_out_valid}, {159'd0, b_vld_m});
            if (!b_vld_m) expect_eq("b_ctrl_bubble", {156'd0, b_out_ctrl}, 160'd0);
            expect_eq("b_stall_cnt", {156'd0, b_stall_cnt}, {156'd0, b_stall_exp});
            if (rst) begin
                qb.delete();
                b_stall_exp = '0;
            end else begin
                if (b_vld_m && b_out_ready) begin
                    b_beat = qb.pop_front();
                    expect_eq("b_out_beat", {148'd0, b_out_data, b_out_ctrl}, {148'd0, b_beat});
                end
                if (b_in_valid && b_rdy_m) qb.push_back({b_in_data, b_in_ctrl});
                if (b_flush) qb.delete();
                if (b_vld_m && !b_out_ready && b_stall_exp != 4'hF) b_stall_exp = b_stall_exp + 4'd1;
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_in_ctrl = '0; a_flush = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_in_ctrl = '0; b_flush = 0; b_out_ready = 0;
        a_stall_exp = '0;
        b_stall_exp = '0;

        // reset
        tick();
        mon_en = 1'b1;
        tick();
        #2;
        expect_eq("rst_a_out_valid", {159'd0, a_out_valid}, 160'd0);
        expect_eq("rst_a_out_ctrl", {136'd0, a_out_ctrl}, 160'd0);
        expect_eq("rst_a_out_data", {32'd0, a_out_data}, 160'd0);
        expect_eq("rst_a_stall", {144'd0, a_stall_cnt}, 160'd0);
        expect_eq("rst_a_in_ready", {159'd0, a_in_ready}, 160'd0);
        expect_eq("rst_b_in_ready", {159'd0, b_in_ready}, 160'd0);
        rst = 1'b0;
        tick();
        #2;
        expect_eq("post_rst_a_in_ready", {159'd0, a_in_ready}, 160'd1);
        expect_eq("post_rst_b_in_ready", {159'd0, b_in_ready}, 160'd1);

        // streaming 1..8 with out_ready held high
        tick();
        a_out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1;
            a_in_data  = 128'(i);
            a_in_ctrl  = 24'h5A5A5A;
            if (i == 2) begin
                #2;
                expect_eq("stream_lat_valid", {159'd0, a_out_valid}, 160'd1);
                expect_eq("stream_lat_data", {32'd0, a_out_data}, 160'd1);
            end
            tick();
        end
        a_in_valid = 0;
        tick();
        tick();
        expect_eq("stream_stall", {144'd0, a_stall_cnt}, 160'd0);

        // backpressure: A to main, B to skid, C waits on in_ready
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 128'hA; a_in_ctrl = 24'h00000A;
        tick();
        a_in_data = 128'hB; a_in_ctrl = 24'h00000B;
        tick();
        a_in_data = 128'hC; a_in_ctrl = 24'h00000C;
        #2;
        expect_eq("bp_in_ready_low", {159'd0, a_in_ready}, 160'd0);
        tick();
        tick();
        tick();
        a_out_ready = 1;
        tick();
        #2;
        expect_eq("bp_in_ready_back", {159'd0, a_in_ready}, 160'd1);
        tick();
        a_in_valid = 0;
        tick();
        tick();
        expect_eq("bp_stall", {144'd0, a_stall_cnt}, 160'd4);

        // flush in FULL with incoming D
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 128'hE; a_in_ctrl = 24'h0000EE;
        tick();
        a_in_data = 128'hF; a_in_ctrl = 24'h0000FF;
        tick();
        a_in_data = 128'hD; a_in_ctrl = 24'h0000DD; a_flush = 1;
        tick();
        a_in_valid = 0; a_flush = 0;
        #2;
        expect_eq("flush_full_valid", {159'd0, a_out_valid}, 160'd0);
        expect_eq("flush_full_ctrl", {136'd0, a_out_ctrl}, 160'd0);
        // flush in ONE while a beat is actually accepted
        a_in_valid = 1; a_in_data = 128'h6; a_in_ctrl = 24'h000066;
        tick();
        a_in_data = 128'h7; a_in_ctrl = 24'h000077; a_flush = 1;
        tick();
        a_in_valid = 0; a_flush = 0; a_out_ready = 1;
        #2;
        expect_eq("flush_one_valid", {159'd0, a_out_valid}, 160'd0);
        tick();
        tick();

        // SKID=0: in_ready tracks out_ready combinationally
        b_in_valid = 1; b_in_data = 8'h11; b_in_ctrl = 4'h3; b_out_ready = 0;
        tick();
        for (int i = 0; i < 6; i++) begin
            b_out_ready = i[0];
            b_in_data   = 8'(8'h20 + i);
            #2;
            expect_eq("b_rdy_follow", {159'd0, b_in_ready}, {159'd0, b_out_ready});
            tick();
        end
        b_in_valid = 0; b_out_ready = 1;
        tick();
        tick();

        // counter saturation at 15
        b_in_valid = 1; b_in_data = 8'h5C; b_in_ctrl = 4'h9; b_out_ready = 0;
        tick();
        b_in_valid = 0;
        for (int i = 0; i < 20; i++) tick();
        expect_eq("b_sat", {156'd0, b_stall_cnt}, 160'd15);
        tick();
        tick();
        tick();
        expect_eq("b_sat_hold", {156'd0, b_stall_cnt}, 160'd15);
        b_out_ready = 1;
        tick();
        tick();

        // reset mid-stream with both entries valid, flush asserted alongside
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 128'h51; a_in_ctrl = 24'h000051;
        tick();
        a_in_data = 128'h52; a_in_ctrl = 24'h000052;
        tick();
        a_in_valid = 0; rst = 1; a_flush = 1;
        tick();
        #2;
        expect_eq("mid_rst_valid", {159'd0, a_out_valid}, 160'd0);
        expect_eq("mid_rst_ctrl", {136'd0, a_out_ctrl}, 160'd0);
        expect_eq("mid_rst_data", {32'd0, a_out_data}, 160'd0);
        expect_eq("mid_rst_stall", {144'd0, a_stall_cnt}, 160'd0);
        expect_eq("mid_rst_b_stall", {156'd0, b_stall_cnt}, 160'd0);
        expect_eq("mid_rst_in_ready", {159'd0, a_in_ready}, 160'd0);
        a_flush = 0; rst = 0;
        #1;
        expect_eq("mid_rst_release", {159'd0, a_in_ready}, 160'd1);
        tick();

        // random traffic on both instances
        for (int i = 0; i < 120; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = {$urandom, $urandom, $urandom, $urandom};
            a_in_ctrl   = 24'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_flush     = ($urandom_range(0, 15) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = 8'($urandom);
            b_in_ctrl   = 4'($urandom);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        a_in_valid = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_flush = 0; b_out_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        expect_eq("a_drained", 160'(qa.size()), 160'd0);
        expect_eq("b_drained", 160'(qb.size()), 160'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
